// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the ID-stage branch resolver: opcodes, predictor
// counter encodings and the saturating counter update.
package branch_resolve_unit_pkg;

    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ   = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e BHT_RESET = WNT;

    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_e'(2'(c) + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_e'(2'(c) - 2'd1);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters with a one-deep registered
// update stage; lookups that hit the pending update see the post-update value.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             pred_o,
    input  logic             res_valid_i,
    input  logic [IDX_W-1:0] res_idx_i,
    input  logic             res_taken_i
);

    ctr_e             table_q [DEPTH];
    logic             upd_valid_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic             upd_taken_q;
    ctr_e             upd_ctr;
    ctr_e             lookup_ctr;

    assign upd_ctr = ctr_next(table_q[upd_idx_q], upd_taken_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= BHT_RESET;
            end
        end else begin
            upd_valid_q <= res_valid_i;
            upd_idx_q   <= res_idx_i;
            upd_taken_q <= res_taken_i;
            if (upd_valid_q) begin
                table_q[upd_idx_q] <= upd_ctr;
            end
        end
    end

    always_comb begin
        lookup_ctr = table_q[lookup_idx_i];
        if (upd_valid_q && (lookup_idx_i == upd_idx_q)) begin
            lookup_ctr = upd_ctr;
        end
    end

    assign pred_o = lookup_ctr[1];

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: operand forwarding, load-use stall, mispredict
// flush/redirect and statistics. Define BRANCH_PREDICT_EN to build the 2-bit BHT.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              id_pred_taken,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [15:0]       imm,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic [4:0]        ex_wdst,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              mem_regwr,
    input  logic [4:0]        mem_wdst,
    input  logic [DATA_W-1:0] mem_fwd_data,
    output logic              br_stall,
    output logic              br_flush,
    output logic [PC_W-1:0]   br_redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic is_beq, is_bne, is_blez, is_bgtz, is_bgez, is_bltz, is_branch;
    logic [DATA_W-1:0] r1, r2;
    logic r1_neg, r1_zero, taken, resolve, mispred;
    logic [PC_W-1:0] seq_pc, br_off, target;
    logic [STAT_W-1:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
    logic unused_if_pc;

    always_comb begin
        is_beq    = (op == OP_BEQ);
        is_bne    = (op == OP_BNE);
        is_blez   = (op == OP_BLEZ);
        is_bgtz   = (op == OP_BGTZ);
        is_bgez   = (op == OP_REGIMM) && (rt == RT_BGEZ);
        is_bltz   = (op == OP_REGIMM) && (rt == RT_BLTZ);
        is_branch = is_beq | is_bne | is_blez | is_bgtz | is_bgez | is_bltz;
    end

    // MEM assigned first so a matching EX producer overrides it.
    always_comb begin
        r1 = rd1;
        r2 = rd2;
        if ((rs != 5'd0) && mem_regwr && (mem_wdst == rs)) r1 = mem_fwd_data;
        if ((rs != 5'd0) && ex_regwr && !ex_memrd && (ex_wdst == rs)) r1 = ex_alu_out;
        if ((rt != 5'd0) && mem_regwr && (mem_wdst == rt)) r2 = mem_fwd_data;
        if ((rt != 5'd0) && ex_regwr && !ex_memrd && (ex_wdst == rt)) r2 = ex_alu_out;
    end

    assign r1_neg  = r1[DATA_W-1];
    assign r1_zero = (r1 == '0);

    assign taken = (is_beq  && (r1 == r2))
                 | (is_bne  && (r1 != r2))
                 | (is_bgtz && !r1_neg && !r1_zero)
                 | (is_blez && (r1_neg || r1_zero))
                 | (is_bgez && !r1_neg)
                 | (is_bltz && r1_neg);

    assign br_stall = id_valid && is_branch && ex_memrd && (ex_wdst != 5'd0)
                    && ((ex_wdst == rs) || ((is_beq || is_bne) && (ex_wdst == rt)));
    assign resolve  = id_valid && is_branch && !br_stall;
    assign mispred  = resolve && (taken != id_pred_taken);

    assign seq_pc = id_pc + PC_W'(4);
    assign br_off = {{(PC_W-18){imm[15]}}, imm, 2'b00};
    assign target = seq_pc + br_off;

    assign br_flush       = mispred;
    assign br_redirect_pc = mispred ? (taken ? target : seq_pc) : '0;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (resolve && !(&stat_br_q)) stat_br_d = stat_br_q + STAT_W'(1);
        if (mispred && !(&stat_mp_q)) stat_mp_d = stat_mp_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;

`ifdef BRANCH_PREDICT_EN
    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk_i        (clk),
        .rst_ni       (rst),
        .lookup_idx_i (if_pc[IDX_W+1:2]),
        .pred_o       (if_pred_taken),
        .res_valid_i  (resolve),
        .res_idx_i    (id_pc[IDX_W+1:2]),
        .res_taken_i  (taken)
    );
`else
    assign if_pred_taken = 1'b0;
`endif

    assign unused_if_pc = ^if_pc;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; predictor expectations follow
// BRANCH_PREDICT_EN, static not-taken otherwise.
module tb_branch_resolve_unit;

    localparam logic [5:0] BEQ  = 6'd4;
    localparam logic [5:0] BNE  = 6'd5;
    localparam logic [5:0] BLEZ = 6'd6;
    localparam logic [5:0] BGTZ = 6'd7;
    localparam logic [5:0] RIMM = 6'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, id_pc, rd1, rd2, ex_alu_out, mem_fwd_data;
    logic [31:0] br_redirect_pc, stat_branches, stat_mispred;
    logic        if_pred_taken, id_valid, id_pred_taken, ex_regwr, ex_memrd, mem_regwr;
    logic        br_stall, br_flush;
    logic [5:0]  op;
    logic [4:0]  rs, rt, ex_wdst, mem_wdst;
    logic [15:0] imm;

    int checks = 0;
    int failures = 0;
    int exp_br = 0;
    int exp_mp = 0;
    logic [1:0] bht_m [64];

    typedef struct {
        string       tag;
        logic        stall;
        logic        flush;
        logic [31:0] redir;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DATA_W    (32),
        .PC_W      (32),
        .BHT_DEPTH (64),
        .STAT_W    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .op             (op),
        .rs             (rs),
        .rt             (rt),
        .imm            (imm),
        .rd1            (rd1),
        .rd2            (rd2),
        .ex_regwr       (ex_regwr),
        .ex_memrd       (ex_memrd),
        .ex_wdst        (ex_wdst),
        .ex_alu_out     (ex_alu_out),
        .mem_regwr      (mem_regwr),
        .mem_wdst       (mem_wdst),
        .mem_fwd_data   (mem_fwd_data),
        .br_stall       (br_stall),
        .br_flush       (br_flush),
        .br_redirect_pc (br_redirect_pc),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic tk);
        if (tk) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
        logic [5:0] ix;
        ix = pc[7:2];
        return bht_m[ix][1];
`else
        return 1'b0 & pc[0];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        exp_br = 0;
        exp_mp = 0;
    endtask

    task automatic clear_fwd();
        ex_regwr = 1'b0; ex_memrd = 1'b0; ex_wdst = 5'd0; ex_alu_out = 32'd0;
        mem_regwr = 1'b0; mem_wdst = 5'd0; mem_fwd_data = 32'd0;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".branches"}, stat_branches, exp_br);
        chk({tag, ".mispred"}, stat_mispred, exp_mp);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic issue(input string tag, input logic [31:0] pc, input logic [5:0] o,
                         input logic [4:0] s, input logic [4:0] t, input logic [15:0] im,
                         input logic [31:0] a, input logic [31:0] b, input logic pr,
                         input logic is_br, input logic stl, input logic tk);
        exp_t        e;
        logic [31:0] tgt;
        logic        res, fl;
        logic [5:0]  ix;
        id_valid = 1'b1; id_pc = pc; op = o; rs = s; rt = t; imm = im;
        rd1 = a; rd2 = b; id_pred_taken = pr;
        tgt = pc + 32'd4 + {{14{im[15]}}, im, 2'b00};
        res = is_br && !stl;
        fl  = res && (tk != pr);
        e.tag = tag; e.stall = stl; e.flush = fl;
        e.redir = fl ? (tk ? tgt : pc + 32'd4) : 32'd0;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".stall"}, br_stall, e.stall);
        chk({e.tag, ".flush"}, br_flush, e.flush);
        chk({e.tag, ".redir"}, br_redirect_pc, e.redir);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        if (res) begin
            exp_br++;
            if (fl) exp_mp++;
            ix = pc[7:2];
            bht_m[ix] = sat2(bht_m[ix], tk);
        end
        if_pc = pc;
        #1;
        chk({e.tag, ".pred"}, if_pred_taken, model_pred(pc));
        check_stats(e.tag);
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [31:0] pc);
        if_pc = pc;
        #1;
        chk(tag, if_pred_taken, model_pred(pc));
    endtask

    logic [31:0] sv_vals [3];
    logic [5:0]  s_ops   [4];
    logic [4:0]  s_rts   [4];
    logic [2:0]  s_exp   [4];

    initial begin
        rst = 1'b0;
        if_pc = 32'd0; id_pc = 32'd0; rd1 = 32'd0; rd2 = 32'd0;
        id_valid = 1'b0; id_pred_taken = 1'b0; op = 6'd0; rs = 5'd0; rt = 5'd0; imm = 16'd0;
        clear_fwd();
        model_reset();
        #1;
        chk("rst.stall", br_stall, 1'b0);
        chk("rst.flush", br_flush, 1'b0);
        chk("rst.redir", br_redirect_pc, 32'd0);
        chk("rst.pred", if_pred_taken, 1'b0);
        check_stats("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic BEQ mispredicts, forward and backward targets, not-taken redirect.
        issue("beq_tk", 32'h1000, BEQ, 5'd1, 5'd2, 16'h0010, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("beq_neg", 32'h1000, BEQ, 5'd1, 5'd2, 16'hFFFE, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("beq_nt", 32'h1010, BEQ, 5'd1, 5'd2, 16'h0020, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use: stall one cycle, then resolve with MEM-forwarded data.
        ex_regwr = 1'b1; ex_memrd = 1'b1; ex_wdst = 5'd8; ex_alu_out = 32'hDEAD;
        issue("lu_stall", 32'h2000, BEQ, 5'd8, 5'd3, 16'h0004, 32'd1, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        issue("lu_rt", 32'h2000, BNE, 5'd3, 5'd8, 16'h0004, 32'd1, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        issue("lu_onesrc", 32'h2040, BGTZ, 5'd1, 5'd8, 16'h0004, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        clear_fwd();
        mem_regwr = 1'b1; mem_wdst = 5'd8; mem_fwd_data = 32'h55;
        issue("lu_res", 32'h2000, BEQ, 5'd8, 5'd3, 16'h0004, 32'd1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        clear_fwd();
        ex_regwr = 1'b1; ex_memrd = 1'b1; ex_wdst = 5'd0;
        issue("lu_zero", 32'h2080, BEQ, 5'd0, 5'd0, 16'h0004, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);

        // EX beats MEM; $0 never forwarded.
        clear_fwd();
        ex_regwr = 1'b1; ex_wdst = 5'd9; ex_alu_out = 32'd7;
        mem_regwr = 1'b1; mem_wdst = 5'd9; mem_fwd_data = 32'd3;
        issue("fwd_bne0", 32'h3000, BNE, 5'd9, 5'd0, 16'h0002, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("fwd_pri", 32'h3010, BNE, 5'd9, 5'd10, 16'h0002, 32'd3, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        issue("fwd_mem", 32'h3020, BEQ, 5'd10, 5'd9, 16'h0002, 32'd3, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_wdst = 5'd0; ex_alu_out = 32'd5; mem_wdst = 5'd0; mem_fwd_data = 32'd6;
        issue("fwd_r0", 32'h3030, BEQ, 5'd0, 5'd11, 16'h0002, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        clear_fwd();

        // Predictor training at one index, bypass and other-index lookups.
        for (int k = 0; k < 3; k++) begin
            issue("bht_tk", 32'h104, BEQ, 5'd1, 5'd2, 16'h0008, 32'd4, 32'd4,
                  model_pred(32'h104), 1'b1, 1'b0, 1'b1);
        end
        look("bht_other", 32'h108);
        issue("bht_nt", 32'h104, BNE, 5'd1, 5'd2, 16'h0008, 32'd4, 32'd4,
              model_pred(32'h104), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        look("bht_tbl", 32'h104);
        look("bht_tbl_other", 32'h108);

        // Signed single-operand conditions.
        sv_vals[0] = 32'h8000_0000; sv_vals[1] = 32'd0; sv_vals[2] = 32'd1;
        s_ops[0] = RIMM; s_rts[0] = 5'd1; s_exp[0] = 3'b110;
        s_ops[1] = RIMM; s_rts[1] = 5'd0; s_exp[1] = 3'b001;
        s_ops[2] = BGTZ; s_rts[2] = 5'd0; s_exp[2] = 3'b100;
        s_ops[3] = BLEZ; s_rts[3] = 5'd0; s_exp[3] = 3'b011;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                issue($sformatf("sgn%0d_%0d", k, j), 32'h4000 + 32'(16 * (3 * k + j)), s_ops[k],
                      5'd1, s_rts[k], 16'h0010, sv_vals[j], 32'd0, 1'((k + j) % 2),
                      1'b1, 1'b0, s_exp[k][j]);
            end
        end
        issue("rimm_rt2", 32'h4100, RIMM, 5'd1, 5'd2, 16'h0010, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("nonbr", 32'h4110, 6'd0, 5'd1, 5'd2, 16'h0010, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset with an update pending: the write must be discarded.
        issue("rst_pend", 32'h20C, BNE, 5'd1, 5'd2, 16'h0004, 32'd1, 32'd2,
              model_pred(32'h20C), 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        check_stats("rst_mid");
        look("rst_mid.pred", 32'h20C);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        look("rst_after.pend", 32'h20C);
        look("rst_after.trained", 32'h104);
        check_stats("rst_after");
        chk("rst_after.flush", br_flush, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
